// File: rtl/sad_pkg.sv
// Shared constants and FSM state type for the SAD search-window index generator.
package sad_pkg;
   localparam int WIN_SHIFT = 6;
   localparam int WIN_SIZE  = 1 << WIN_SHIFT;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/sad_index_gen_if.sv
// Scan request plus index-stream handshake between the generator and its consumer.
interface sad_index_gen_if #(
   parameter int IDX_W     = 32,
   parameter int WIN_SHIFT = sad_pkg::WIN_SHIFT
);
   logic                 Start;
   logic [WIN_SHIFT-1:0] X0;
   logic [WIN_SHIFT-1:0] Y0;
   logic [WIN_SHIFT:0]   XLen;
   logic [WIN_SHIFT:0]   YLen;
   logic                 IdxValid;
   logic                 IdxReady;
   logic [IDX_W-1:0]     Index;
   logic [WIN_SHIFT-1:0] X;
   logic [WIN_SHIFT-1:0] Y;
   logic                 Last;
   logic                 Busy;
   logic                 Done;

   // master: the generator (drives the index stream)
   modport master (
      input  Start, X0, Y0, XLen, YLen, IdxReady,
      output IdxValid, Index, X, Y, Last, Busy, Done
   );

   // slave: the requester / index consumer
   modport slave (
      output Start, X0, Y0, XLen, YLen, IdxReady,
      input  IdxValid, Index, X, Y, Last, Busy, Done
   );
endinterface

// File: rtl/sad_coord_to_index.sv
// Packs a window coordinate into the linear SAD index: (X << WIN_SHIFT) | Y, zero-extended.
module sad_coord_to_index #(
   parameter int IDX_W     = 32,
   parameter int WIN_SHIFT = sad_pkg::WIN_SHIFT
) (
   input  logic [WIN_SHIFT-1:0] x_i,
   input  logic [WIN_SHIFT-1:0] y_i,
   output logic [IDX_W-1:0]     index_o
);
   assign index_o = IDX_W'({x_i, y_i});
endmodule

// File: rtl/sad_index_gen.sv
// Column-major scan of a rectangular region of the search window, one index per accepted transfer.
// Define SAD_INDEX_SERPENTINE_EN for a boustrophedon scan (Y reverses direction on odd columns).
module sad_index_gen #(
   parameter int IDX_W     = 32,
   parameter int WIN_SHIFT = sad_pkg::WIN_SHIFT
) (
   input  logic            Clk,
   input  logic            Rst,
   sad_index_gen_if.master bus
);
   import sad_pkg::*;

   state_t               state_q, state_d;
   logic [WIN_SHIFT-1:0] x_q, x_d;
   logic [WIN_SHIFT-1:0] y_q, y_d;
   logic [WIN_SHIFT-1:0] row_q, row_d;
   logic [WIN_SHIFT-1:0] col_q, col_d;
   logic [WIN_SHIFT-1:0] y0_q;
   logic [WIN_SHIFT-1:0] xm1_q;
   logic [WIN_SHIFT-1:0] ym1_q;

   logic start_acc;
   logic col_end;
   logic last_pos;

   assign start_acc = (state_q == IDLE) && bus.Start;
   assign col_end   = (row_q == ym1_q);
   assign last_pos  = col_end && (col_q == xm1_q);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      row_d   = row_q;
      col_d   = col_q;
      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               state_d = RUN;
               x_d     = bus.X0;
               y_d     = bus.Y0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         RUN: begin
            if (bus.IdxReady) begin
               if (last_pos) begin
                  state_d = DONE;
               end else if (col_end) begin
                  row_d = '0;
                  col_d = col_q + WIN_SHIFT'(1);
                  x_d   = x_q + WIN_SHIFT'(1);
`ifdef SAD_INDEX_SERPENTINE_EN
                  y_d   = y_q;
`else
                  y_d   = y0_q;
`endif
               end else begin
                  row_d = row_q + WIN_SHIFT'(1);
`ifdef SAD_INDEX_SERPENTINE_EN
                  y_d   = col_q[0] ? (y_q - WIN_SHIFT'(1)) : (y_q + WIN_SHIFT'(1));
`else
                  y_d   = y_q + WIN_SHIFT'(1);
`endif
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Length minus one modulo the window size maps both 0 and 64 to 63.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         row_q   <= '0;
         col_q   <= '0;
         y0_q    <= '0;
         xm1_q   <= '0;
         ym1_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         row_q   <= row_d;
         col_q   <= col_d;
         if (start_acc) begin
            y0_q  <= bus.Y0;
            xm1_q <= WIN_SHIFT'(bus.XLen - (WIN_SHIFT + 1)'(1));
            ym1_q <= WIN_SHIFT'(bus.YLen - (WIN_SHIFT + 1)'(1));
         end
      end
   end

   assign bus.IdxValid = (state_q == RUN);
   assign bus.Busy     = (state_q == RUN);
   assign bus.Done     = (state_q == DONE);
   assign bus.Last     = (state_q == RUN) && last_pos;
   assign bus.X        = x_q;
   assign bus.Y        = y_q;

   sad_coord_to_index #(
      .IDX_W     (IDX_W),
      .WIN_SHIFT (WIN_SHIFT)
   ) u_pack (
      .x_i     (x_q),
      .y_i     (y_q),
      .index_o (bus.Index)
   );
endmodule

// File: tb/tb_sad_index_gen.sv
// Randomized and directed scans of sad_index_gen checked against a nested-loop reference model.
module tb_sad_index_gen;
   localparam int IDX_W = 32;
   localparam int WS    = 6;
   localparam int WSZ   = 1 << WS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sad_index_gen_if #(.IDX_W(IDX_W), .WIN_SHIFT(WS)) bus();

   sad_index_gen #(.IDX_W(IDX_W), .WIN_SHIFT(WS)) dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   int exp_q[$];
   int obs_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference: nested column/row loops over the region, coordinates taken mod 64.
   function automatic void build_exp(input int x0, input int y0, input int xl, input int yl);
      int xn, yn, y;
      xn = (xl == 0) ? WSZ : xl;
      yn = (yl == 0) ? WSZ : yl;
      exp_q.delete();
      for (int c = 0; c < xn; c++) begin
         for (int r = 0; r < yn; r++) begin
`ifdef SAD_INDEX_SERPENTINE_EN
            y = (c % 2 == 0) ? (y0 + r) : (y0 + yn - 1 - r);
`else
            y = y0 + r;
`endif
            exp_q.push_back((((x0 + c) % WSZ) * WSZ) + (y % WSZ));
         end
      end
   endfunction

   task automatic drive_start(input int x0, input int y0, input int xl, input int yl);
      bus.X0    = WS'(x0);
      bus.Y0    = WS'(y0);
      bus.XLen  = (WS + 1)'(xl);
      bus.YLen  = (WS + 1)'(yl);
      bus.Start = 1'b1;
   endtask

   // Runs one scan; every cycle with IdxValid the outputs must equal the model's head entry.
   task automatic run_scan(input string tag, input int x0, input int y0, input int xl, input int yl,
                           input int ready_pct, input int stall_at, input bit mid_start, input bit pre);
      int cyc, n, stall;
      bit rdy;
      build_exp(x0, y0, xl, yl);
      obs_q.delete();
      if (!pre) begin
         @(negedge clk);
         drive_start(x0, y0, xl, yl);
         bus.IdxReady = 1'b0;
      end
      @(negedge clk);
      bus.Start = 1'b0;
      cyc = 0; n = 0; stall = 0;
      while (exp_q.size() > 0 && cyc < 20000) begin
         chk({tag, " valid"}, 64'(bus.IdxValid), 64'd1);
         chk({tag, " busy"},  64'(bus.Busy),     64'd1);
         chk({tag, " done"},  64'(bus.Done),     64'd0);
         chk({tag, " index"}, 64'(bus.Index),    64'(exp_q[0]));
         chk({tag, " x"},     64'(bus.X),        64'(exp_q[0] / WSZ));
         chk({tag, " y"},     64'(bus.Y),        64'(exp_q[0] % WSZ));
         chk({tag, " last"},  64'(bus.Last),     64'(exp_q.size() == 1));
         if (mid_start && n == 1) drive_start($urandom_range(0, 63), $urandom_range(0, 63), 5, 5);
         else bus.Start = 1'b0;
         if (stall_at == n && stall < 3) begin
            rdy = 1'b0;
            stall++;
         end else begin
            rdy = ($urandom_range(0, 99) < ready_pct);
         end
         bus.IdxReady = rdy;
         if (rdy) begin
            obs_q.push_back(int'(bus.Index));
            void'(exp_q.pop_front());
            n++;
         end
         @(negedge clk);
         cyc++;
      end
      bus.Start    = 1'b0;
      bus.IdxReady = 1'b0;
      chk({tag, " timeout"}, 64'(exp_q.size()), 64'd0);
      chk({tag, " done pulse"},  64'(bus.Done),     64'd1);
      chk({tag, " valid after"}, 64'(bus.IdxValid), 64'd0);
      chk({tag, " busy after"},  64'(bus.Busy),     64'd0);
      @(negedge clk);
      chk({tag, " done clear"},  64'(bus.Done),     64'd0);
      $display("scan %s x0=%0d y0=%0d xl=%0d yl=%0d transfers=%0d", tag, x0, y0, xl, yl, obs_q.size());
   endtask

   task automatic chk_seq(input string tag, input int ref_seq[]);
      chk({tag, " len"}, 64'(obs_q.size()), 64'(ref_seq.size()));
      for (int i = 0; i < ref_seq.size() && i < obs_q.size(); i++)
         chk({tag, " seq"}, 64'(obs_q[i]), 64'(ref_seq[i]));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " valid"}, 64'(bus.IdxValid), 64'd0);
      chk({tag, " index"}, 64'(bus.Index),    64'd0);
      chk({tag, " x"},     64'(bus.X),        64'd0);
      chk({tag, " y"},     64'(bus.Y),        64'd0);
      chk({tag, " last"},  64'(bus.Last),     64'd0);
      chk({tag, " busy"},  64'(bus.Busy),     64'd0);
      chk({tag, " done"},  64'(bus.Done),     64'd0);
   endtask

   int seq_a[];
   int seq_b[];

   initial begin
      bus.Start    = 1'b0;
      bus.X0       = '0;
      bus.Y0       = '0;
      bus.XLen     = '0;
      bus.YLen     = '0;
      bus.IdxReady = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

`ifdef SAD_INDEX_SERPENTINE_EN
      seq_a = '{0, 1, 2, 66, 65, 64};
      seq_b = '{4094, 4095, 63, 62};
`else
      seq_a = '{0, 1, 2, 64, 65, 66};
      seq_b = '{4094, 4095, 62, 63};
`endif

      run_scan("basic", 0, 0, 2, 3, 100, -1, 1'b0, 1'b0);
      chk_seq("basic", seq_a);
      run_scan("stall", 0, 0, 2, 3, 100, 1, 1'b0, 1'b0);
      chk_seq("stall", seq_a);
      run_scan("wrap", 63, 62, 2, 2, 100, -1, 1'b0, 1'b0);
      chk_seq("wrap", seq_b);
      run_scan("midstart", 0, 0, 0, 1, 100, -1, 1'b1, 1'b0);
      chk("midstart len", 64'(obs_q.size()), 64'd64);
      chk("midstart end", 64'(obs_q[obs_q.size() - 1]), 64'd4032);

      // Reset in the middle of a scan, then Start on the first edge after release.
      @(negedge clk);
      drive_start(0, 0, 2, 3);
      @(negedge clk);
      bus.Start    = 1'b0;
      bus.IdxReady = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk_all_zero("midreset");
      @(negedge clk);
      rst = 1'b0;
      drive_start(10, 20, 3, 2);
      bus.IdxReady = 1'b0;
      run_scan("postreset", 10, 20, 3, 2, 70, -1, 1'b0, 1'b1);

      for (int k = 0; k < 8; k++)
         run_scan("rand", $urandom_range(0, 63), $urandom_range(0, 63),
                  $urandom_range(0, 9), $urandom_range(0, 9), 60, $urandom_range(0, 5), 1'b0, 1'b0);
      run_scan("full", 0, 0, 0, 0, 100, -1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
